mdu_iter: RTL

- Parametrised, iterative multiply/divide unit for the 5-stage MIPS pipeline.
- Executes MULT/MULTU/DIV/DIVU into architectural HI/LO registers, and also handles MTHI/MTLO.
- Sits beside the EX stage and takes forwarded operands. It raises `busy` so the hazard unit can stall IF/ID/EX while an operation runs.
- Supports flush, so wrong-path operations can be aborted.

---
 rtl/mdu_iter.sv | 118 +++++++++++
 1 files changed

// File: rtl/mdu_iter.sv
// mdu_iter: iterative MIPS HI/LO mult/div unit (MULT/MULTU/DIV/DIVU/MTHI/MTLO; ports clk reset start op rs_val rt_val flush -> busy done div_by_zero hi lo; `MDU_EARLY_OUT_EN enables multiply early-out)
module mdu_iter #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] rs_val,
  input  logic [DATA_WIDTH-1:0] rt_val,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);
  localparam int W = DATA_WIDTH;
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_WIDTH-1:0] cnt;
  logic [W-1:0] hi_w, lo_w, b_w, rem, a_raw, a_abs, b_abs;
  logic [2*W-1:0] mc;
  logic [W:0] r_sh, diff;
  logic neg_q, neg_r, is_div, dz, last, go, sa, sb;
  assign go    = start & ~flush;
  assign sa    = op[0] & rs_val[W-1];
  assign sb    = op[0] & rt_val[W-1];
  assign a_abs = sa ? -rs_val : rs_val;
  assign b_abs = sb ? -rt_val : rt_val;
  assign r_sh  = {rem, lo_w[W-1]};
  assign diff  = r_sh - {1'b0, b_w};
`ifdef MDU_EARLY_OUT_EN
  assign last = (cnt == CNT_WIDTH'(W - 1)) | (state == MUL && b_w[W-1:1] == '0);
`else
  assign last = cnt == CNT_WIDTH'(W - 1);
`endif
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (go && !op[2]) ? (op[1] ? DIV : MUL) : IDLE;
      MUL,
      DIV:     state_nx = flush ? IDLE : (last ? FIX : state);
      FIX:     state_nx = flush ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb busy = state == MUL || state == DIV || state == FIX;
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
      cnt <= '0;
      hi_w <= '0;
      lo_w <= '0;
      b_w <= '0;
      rem <= '0;
      mc <= '0;
      a_raw <= '0;
      {neg_q, neg_r, is_div, dz} <= '0;
    end else begin
      done <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: if (go) begin
          if (op == 3'b100) hi <= rs_val;
          else if (op == 3'b101) lo <= rs_val;
          else if (!op[2]) begin
            hi_w <= '0;
            lo_w <= op[1] ? a_abs : '0;
            mc <= {{W{1'b0}}, a_abs};
            b_w <= b_abs;
            rem <= '0;
            cnt <= '0;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            is_div <= op[1];
            dz <= op[1] & (rt_val == '0);
            a_raw <= rs_val;
          end
        end
        MUL: begin
          {hi_w, lo_w} <= {hi_w, lo_w} + (b_w[0] ? mc : '0);
          mc <= mc << 1;
          b_w <= b_w >> 1;
          cnt <= cnt + 1'b1;
        end
        DIV: begin
          rem <= diff[W] ? r_sh[W-1:0] : diff[W-1:0];
          lo_w <= {lo_w[W-2:0], ~diff[W]};
          cnt <= cnt + 1'b1;
        end
        FIX:
          if (dz) begin
            hi_w <= a_raw;
            lo_w <= '1;
          end else if (is_div) begin
            hi_w <= neg_r ? -rem : rem;
            lo_w <= neg_q ? -lo_w : lo_w;
          end else {hi_w, lo_w} <= neg_q ? -{hi_w, lo_w} : {hi_w, lo_w};
        DONE: begin
          hi <= hi_w;
          lo <= lo_w;
          done <= 1'b1;
          div_by_zero <= dz;
        end
        default: ;
      endcase
    end
  end
endmodule
